// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam logic [3:0] DEF_PAT_1001 = 4'b1001;

  localparam bit OVL_ON  = 1'b1;
  localparam bit OVL_OFF = 1'b0;

  // Number of bits needed to hold values 0..value-1.
  function automatic int unsigned clog2_fn(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-reloadable pattern, optional overlap and
// a saturating match counter.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int unsigned         PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]  PAT_RST = DEF_PAT_1001,
  parameter bit                  OVERLAP = OVL_ON,
  parameter int unsigned         CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_we,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cnt_clr,
  output logic               d,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [PAT_LEN-1:0] pattern
);

  localparam int unsigned          FILL_W   = clog2_fn(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_q, hist_d, hist_shift;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
  logic               d_q;
  logic               match;

  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    pat_d      = pat_q;
    match      = 1'b0;
    hist_shift = {hist_q[PAT_LEN-2:0], in};
    fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;

    if (cfg_we) begin
      // Reload restarts detection; a bit arriving in the same cycle is dropped.
      pat_d  = cfg_pattern;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      match  = (fill_inc == FILL_MAX) && (hist_shift == pat_q);
      if (match && !OVERLAP) fill_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PAT_RST;
      d_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      d_q    <= match;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match),
    .clr   (cnt_clr),
    .count (match_cnt)
  );

  assign d       = d_q;
  assign pattern = pat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Table-driven bench for seq_detect_param: overlap, non-overlap and 2-bit counter
// instances share one stimulus stream; expectations flow through a scoreboard queue.
module tb_seq_detect_param;
  import seq_det_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in, in_valid, cfg_we, cnt_clr;
  logic [3:0] cfg_pattern;

  logic       d1, d0, d2;
  logic [7:0] c1, c0;
  logic [1:0] c2;
  logic [3:0] p1, p0, p2;

  always #5 clk = ~clk;

  seq_detect_param u_ovl (
    .clk (clk), .rst (rst), .in (in), .in_valid (in_valid), .cfg_we (cfg_we),
    .cfg_pattern (cfg_pattern), .cnt_clr (cnt_clr), .d (d1), .match_cnt (c1), .pattern (p1)
  );

  seq_detect_param #(.OVERLAP (OVL_OFF)) u_novl (
    .clk (clk), .rst (rst), .in (in), .in_valid (in_valid), .cfg_we (cfg_we),
    .cfg_pattern (cfg_pattern), .cnt_clr (cnt_clr), .d (d0), .match_cnt (c0), .pattern (p0)
  );

  seq_detect_param #(.CNT_W (2)) u_sat (
    .clk (clk), .rst (rst), .in (in), .in_valid (in_valid), .cfg_we (cfg_we),
    .cfg_pattern (cfg_pattern), .cnt_clr (cnt_clr), .d (d2), .match_cnt (c2), .pattern (p2)
  );

  typedef struct {
    logic       in_b;
    logic       v;
    logic       we;
    logic [3:0] pat;
    logic       clr;
    logic       d1;  // expected d, overlapping instances
    logic       d0;  // expected d, non-overlapping instance
  } vec_t;

  typedef struct {
    int         idx;
    logic       d1;
    logic       d0;
    logic [7:0] c1;
    logic [7:0] c0;
    logic [1:0] c2;
    logic [3:0] pat;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  exp_t e;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state driven purely by the expected columns of the table.
  logic [7:0] mc1, mc0;
  logic [1:0] mc2;
  logic [3:0] mpat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic in_b, input logic v, input logic we, input logic [3:0] pat,
                     input logic clr, input logic ed1, input logic ed0);
    vec_t r;
    r.in_b = in_b; r.v = v; r.we = we; r.pat = pat; r.clr = clr; r.d1 = ed1; r.d0 = ed0;
    tbl.push_back(r);
  endtask

  task automatic b(input logic in_b, input logic ed1, input logic ed0);
    add(in_b, 1'b1, 1'b0, 4'h0, 1'b0, ed1, ed0);
  endtask

  // Gap cycle: data line deliberately high so an unqualified sample would show up.
  task automatic g();
    add(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      exp_t x;
      @(negedge clk);
      in          = tbl[i].in_b;
      in_valid    = tbl[i].v;
      cfg_we      = tbl[i].we;
      cfg_pattern = tbl[i].pat;
      cnt_clr     = tbl[i].clr;
      if (tbl[i].clr) begin
        mc1 = '0; mc0 = '0; mc2 = '0;
      end else begin
        if (tbl[i].d1 && mc1 != 8'hff) mc1 = mc1 + 1'b1;
        if (tbl[i].d0 && mc0 != 8'hff) mc0 = mc0 + 1'b1;
        if (tbl[i].d1 && mc2 != 2'b11) mc2 = mc2 + 1'b1;
      end
      if (tbl[i].we) mpat = tbl[i].pat;
      x.idx = i; x.d1 = tbl[i].d1; x.d0 = tbl[i].d0;
      x.c1 = mc1; x.c0 = mc0; x.c2 = mc2; x.pat = mpat;
      sb.push_back(x);
    end
    @(negedge clk);
    in = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    tbl.delete();
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("row%0d d_ovl", e.idx), 32'(d1), 32'(e.d1));
      chk($sformatf("row%0d d_novl", e.idx), 32'(d0), 32'(e.d0));
      chk($sformatf("row%0d d_sat", e.idx), 32'(d2), 32'(e.d1));
      chk($sformatf("row%0d cnt_ovl", e.idx), 32'(c1), 32'(e.c1));
      chk($sformatf("row%0d cnt_novl", e.idx), 32'(c0), 32'(e.c0));
      chk($sformatf("row%0d cnt_sat", e.idx), 32'(c2), 32'(e.c2));
      chk($sformatf("row%0d pattern", e.idx), 32'(p1), 32'(e.pat));
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, " d_ovl"}, 32'(d1), 32'd0);
    chk({tag, " d_novl"}, 32'(d0), 32'd0);
    chk({tag, " cnt_ovl"}, 32'(c1), 32'd0);
    chk({tag, " cnt_novl"}, 32'(c0), 32'd0);
    chk({tag, " cnt_sat"}, 32'(c2), 32'd0);
    chk({tag, " pattern"}, 32'(p1), 32'h9);
    chk({tag, " pattern_novl"}, 32'(p0), 32'h9);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; cfg_pattern = 4'h0; cnt_clr = 1'b0;
    mc1 = '0; mc0 = '0; mc2 = '0; mpat = 4'b1001;
    #1;
    chk_reset_state("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Stream 1001001 then 1001: overlap hits bits 4,7,11; non-overlap hits 4,11.
    b(1,0,0); b(0,0,0); b(0,0,0); b(1,1,1); b(0,0,0); b(0,0,0); b(1,1,0);
    b(1,0,0); b(0,0,0); b(0,0,0); b(1,1,1);
    // Re-arm with same pattern and clear counts, then 1001 with 3-cycle gaps.
    add(1, 1, 1, 4'b1001, 1, 0, 0);
    b(1,0,0); g(); g(); g(); b(0,0,0); g(); g(); g(); b(0,0,0); g(); g(); g();
    b(1,1,1); g();
    // Load 1101 with a valid 1 in the same cycle; that bit must not count.
    add(1, 1, 1, 4'b1101, 0, 0, 0);
    b(1,0,0); b(0,0,0); b(1,0,0);
    b(1,0,0); b(0,0,0); b(0,0,0); b(1,0,0);
    b(1,0,0); b(1,0,0); b(0,0,0); b(1,1,1);
    // Back to 1001, partial 100 before the mid-sequence reset.
    add(0, 0, 1, 4'b1001, 0, 0, 0);
    b(1,0,0); b(0,0,0); b(0,0,0);
    run_table();

    // Reset mid-sequence: everything clears immediately, even with valid data present.
    rst = 1'b1; in = 1'b1; in_valid = 1'b1;
    #1;
    chk_reset_state("rst_async");
    @(posedge clk);
    #1;
    chk_reset_state("rst_held");
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    mc1 = '0; mc0 = '0; mc2 = '0; mpat = 4'b1001;

    // Lone 1 must not complete the pre-reset 100; then 001 completes a fresh 1001.
    b(1,0,0); b(0,0,0); b(0,0,0); b(1,1,1);
    // Five overlapping matches saturate the 2-bit counter at 3.
    add(0, 0, 0, 4'h0, 1, 0, 0);
    b(1,0,0); b(0,0,0); b(0,0,0); b(1,1,1);
    b(0,0,0); b(0,0,0); b(1,1,0);
    b(0,0,0); b(0,0,0); b(1,1,1);
    b(0,0,0); b(0,0,0); b(1,1,0);
    b(0,0,0); b(0,0,0); b(1,1,1);
    // Sixth match coincides with a clear: counts go to 0 but d still pulses.
    b(0,0,0); b(0,0,0); add(1, 1, 0, 4'h0, 1, 1, 0);
    g();
    run_table();

    // Reset must restore the default pattern after a reload.
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = 4'b0110;
    @(posedge clk);
    #1;
    chk("reload pattern", 32'(p1), 32'h6);
    @(negedge clk);
    cfg_we = 1'b0;
    rst = 1'b1;
    #1;
    chk("final_rst pattern", 32'(p1), 32'h9);
    chk("final_rst pattern_sat", 32'(p2), 32'h9);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised Moore-style serial pattern detector; next generation of the fixed 4-bit "1001" detector.
- Pattern length, reset pattern and overlap mode are parameters. Pattern is reloadable at runtime.
- Adds a qualified input strobe and a saturating match counter.
- Sits on a serial bit stream (one bit per valid cycle) and feeds status/interrupt logic.

Parameters:
- PAT_LEN, 4, pattern length in bits (>=2).
- PAT_RST, 4'b1001, pattern loaded at reset (PAT_LEN bits, MSB = oldest bit).
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in  in  1  serial data bit.
- in_valid  in  1  qualifies in; bit sampled only when high.
- cfg_we  in  1  load cfg_pattern this cycle.
- cfg_pattern  in  PAT_LEN  new pattern, MSB = first bit of sequence.
- cnt_clr  in  1  synchronous clear of match_cnt.
- d  out  1  detect pulse, registered.
- match_cnt  out  CNT_W  saturating count of detections.
- pattern  out  PAT_LEN  currently active pattern.

Behaviour:
- Reset (rst=1, asynchronous):
  - hist=0, fill=0, d=0, match_cnt=0, pattern=PAT_RST.
- State:
  - hist[PAT_LEN-1:0] is a history shift register.
  - fill is a counter 0..PAT_LEN. It saturates at PAT_LEN and counts valid bits since reset, reload or non-overlap match.
- Sample (in_valid=1, cfg_we=0):
  - hist <= {hist[PAT_LEN-2:0], in}.
  - fill <= min(fill+1, PAT_LEN).
- Match condition, evaluated combinationally on the post-shift values:
  - fill_next==PAT_LEN && hist_next==pattern.
- Output d:
  - Registered. d=1 for exactly the one cycle following the edge that sampled the completing bit.
  - d=0 on every other cycle, including cycles with in_valid=0.
  - Latency from completing bit to d: 1 cycle.
- OVERLAP=1:
  - hist and fill are kept after a match; suffix bits count toward the next match.
- OVERLAP=0:
  - On a match, fill <= 0 (hist may shift normally).
  - The next match requires PAT_LEN fresh bits.
- in_valid=0:
  - hist, fill and d-source are held; d <= 0.
  - Gaps do not break a sequence.
- cfg_we=1:
  - pattern <= cfg_pattern; hist <= 0; fill <= 0; d <= 0.
  - cfg_we has priority over in_valid in the same cycle; that data bit is discarded and not counted.
- match_cnt:
  - Increments on each match edge (the same edge that sets d).
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 sets it to 0.
  - If cnt_clr and a match occur in the same cycle, the result is 0 (clear wins).
  - cfg_we does not affect match_cnt.
- Reset mid-sequence:
  - Partial progress is lost; reset values apply immediately.
  - The first match after release needs PAT_LEN valid bits.

Decomposition:
- Shared package seq_det_pkg holds:
  - Default pattern constant DEF_PAT_1001 = 4'b1001.
  - Overlap-mode constants OVL_ON = 1, OVL_OFF = 0.
  - A clog2-style helper for fill width.
- One natural sub-module: sat_counter (param WIDTH; inputs inc, clr; clr priority), used for match_cnt.

Test Plan:
1. Reset, then stream 1,0,0,1,0,0,1 with in_valid=1 every cycle, OVERLAP=1 -> d high in the cycles after bits 4 and 7; match_cnt=2.
2. Same stream with OVERLAP=0 -> d high only after bit 4; match_cnt=1. Then stream 1,0,0,1 again -> second d; match_cnt=2.
3. Stream 1,0,0,1 with in_valid low for 3 cycles between each bit -> single d pulse one cycle after the final sampled 1; d=0 during gaps.
4. Load cfg_pattern=4'b1101 with in_valid=1 and in=1 in the same cycle -> that bit is ignored and pattern=1101. Then stream 1,0,0,1 -> no d. Then stream 1,1,0,1 -> d pulse.
5. Stream 1,0,0, assert rst for 1 cycle, then stream 1 -> no d. Then stream 0,0,1 -> d. All outputs are 0 while rst is high.
6. CNT_W=2: produce 5 overlapping matches -> match_cnt sticks at 3. Assert cnt_clr together with a 6th match -> match_cnt=0 and d still pulses.
